// File: rtl/uart_rx_deser.sv
// UART 8N1 receiver: oversamples rx on clk, samples each bit at mid-period,
// and emits the byte with a one-cycle valid (good stop) or frame_err (stop low) pulse.
module uart_rx_deser #(
   parameter int unsigned CLKS_PER_BIT = 5210,
   parameter int unsigned CW           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [CW-1:0] TICK_VAL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_VAL = CW'((CLKS_PER_BIT / 2) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state, state_n;
   logic          sync1, rs;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    data_sh, data_sh_n;
   logic [7:0]    data_n;
   logic          valid_n, frame_err_n;
   logic          tick;

   assign tick = (cnt == TICK_VAL);

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b1;
         rs    <= 1'b1;
      end else begin
         sync1 <= rx;
         rs    <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         data_sh   <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         data_sh   <= data_sh_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= frame_err_n;
         busy      <= (state_n != S_IDLE);
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      data_sh_n   = data_sh;
      data_n      = data;
      valid_n     = 1'b0;
      frame_err_n = 1'b0;

      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (!rs) state_n = S_START;
         end

         // Re-check the start bit at its midpoint; a high line there was a glitch.
         S_START: begin
            if (cnt == HALF_VAL) begin
               cnt_n = '0;
               if (rs) begin
                  state_n = S_IDLE;
               end else begin
                  bit_idx_n = '0;
                  state_n   = S_DATA;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         S_DATA: begin
            if (tick) begin
               cnt_n              = '0;
               data_sh_n[bit_idx] = rs;
               bit_idx_n          = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = S_STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
         S_STOP: begin
            if (tick) begin
               cnt_n  = '0;
               data_n = data_sh;
               if (rs) begin
                  valid_n = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = S_BREAK;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         // A held-low line must return high before another start is accepted.
         S_BREAK: begin
            cnt_n = '0;
            if (rs) state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: a fast instance (16 clk/bit) for directed and random
// frames plus a 5210 clk/bit smoke instance, both checked through scoreboards.
module tb_uart_rx_deser;

   localparam int unsigned CPB   = 16;
   localparam int unsigned CPB_B = 5210;

   logic       clk = 1'b0;
   logic       rst_a, rst_b, rx_a, rx_b;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

   always #5 clk = ~clk;

   uart_rx_deser #(.CLKS_PER_BIT(CPB), .CW(16)) dut_a (
      .clk(clk), .rst(rst_a), .rx(rx_a), .data(data_a),
      .valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
   );

   uart_rx_deser #(.CLKS_PER_BIT(CPB_B), .CW(16)) dut_b (
      .clk(clk), .rst(rst_b), .rx(rx_b), .data(data_b),
      .valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
   );

   // Expected entries: {is_frame_err, byte}
   logic [8:0] q_a[$];
   logic [8:0] q_b[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int start_cyc_a = 0;
   int vcyc_a = 0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Line level at offset o cycles after the start edge of a frame.
   function automatic logic line_at(input logic [7:0] b, input int p,
                                    input logic stop_lvl, input int stop_len, input int o);
      if (o < p)                 return 1'b0;
      if (o < 9 * p)             return b[3'(o / p - 1)];
      if (o < 9 * p + stop_len)  return stop_lvl;
      return 1'b1;
   endfunction

   // Receiver samples bit k at cpb/2 + (k+1)*cpb after the start edge, stop at cpb/2 + 9*cpb.
   function automatic logic [8:0] model(input logic [7:0] b, input int p, input int cpb,
                                        input logic stop_lvl, input int stop_len);
      logic [7:0] d;
      logic       s;
      for (int k = 0; k < 8; k++)
         d[k] = line_at(b, p, stop_lvl, stop_len, cpb / 2 + cpb * (k + 1));
      s = line_at(b, p, stop_lvl, stop_len, cpb / 2 + cpb * 9);
      return {~s, d};
   endfunction

   task automatic drive(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
   endtask

   // Called aligned to a negedge; leaves rx at the stop level.
   task automatic send(input bit sel, input logic [7:0] b, input int p, input int cpb,
                       input logic stop_lvl, input int stop_len);
      if (sel) q_b.push_back(model(b, p, cpb, stop_lvl, stop_len));
      else     q_a.push_back(model(b, p, cpb, stop_lvl, stop_len));
      drive(sel, 1'b0);
      if (!sel) start_cyc_a = cyc;
      repeat (p) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(sel, b[i]);
         repeat (p) @(negedge clk);
      end
      drive(sel, stop_lvl);
      repeat (stop_len) @(negedge clk);
   endtask

   task automatic drain(input bit sel, input int maxc);
      int n = 0;
      while ((sel ? q_b.size() : q_a.size()) != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(sel ? "b_drain" : "a_drain", sel ? q_b.size() : q_a.size(), 0);
   endtask

   // Monitor: pop and compare whenever either DUT pulses.
   always @(negedge clk) begin
      logic [8:0] e;
      if (valid_a || ferr_a) begin
         chk("a_exclusive", int'(valid_a & ferr_a), 0);
         chk("a_pulse_width", int'(prev_a), 0);
         if (q_a.size() == 0) begin
            chk("a_unexpected_pulse", q_a.size(), 1);
         end else begin
            e = q_a.pop_front();
            chk("a_data", int'(data_a), int'(e[7:0]));
            chk("a_frame_err", int'(ferr_a), int'(e[8]));
            if (valid_a) vcyc_a = cyc;
         end
      end
      prev_a = valid_a | ferr_a;
      if (valid_b || ferr_b) begin
         chk("b_exclusive", int'(valid_b & ferr_b), 0);
         chk("b_pulse_width", int'(prev_b), 0);
         if (q_b.size() == 0) begin
            chk("b_unexpected_pulse", q_b.size(), 1);
         end else begin
            e = q_b.pop_front();
            chk("b_data", int'(data_b), int'(e[7:0]));
            chk("b_frame_err", int'(ferr_b), int'(e[8]));
         end
      end
      prev_b = valid_b | ferr_b;
   end

   initial begin
      logic [7:0] rb;
      logic       saw_busy;
      rst_a = 1'b0; rst_b = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;
      @(negedge clk);
      chk("rst_data", int'(data_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_frame_err", int'(ferr_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_b_busy", int'(busy_b), 0);

      fork
         begin
            rb = 8'($urandom);
            send(1'b1, rb, CPB_B, CPB_B, 1'b1, CPB_B);
            drain(1'b1, 2 * CPB_B);
         end
         begin
            // Single frame and its latency from the rx pin.
            repeat (4) @(negedge clk);
            send(1'b0, 8'hA5, CPB, CPB, 1'b1, CPB);
            drain(1'b0, 3 * CPB);
            chk("a5_latency", vcyc_a - start_cyc_a, int'(CPB / 2) + 9 * int'(CPB) + 1 + 2);

            // Back-to-back, no idle bit.
            send(1'b0, 8'h00, CPB, CPB, 1'b1, CPB);
            send(1'b0, 8'hFF, CPB, CPB, 1'b1, CPB);
            drain(1'b0, 3 * CPB);

            // Short glitch rejected.
            repeat (5) @(negedge clk);
            saw_busy = 1'b0;
            rx_a = 1'b0;
            repeat (4) begin @(negedge clk); saw_busy |= busy_a; end
            rx_a = 1'b1;
            repeat (20) begin @(negedge clk); saw_busy |= busy_a; end
            chk("glitch_busy_seen", int'(saw_busy), 1);
            chk("glitch_idle", int'(busy_a), 0);

            // Stop bit held low: frame_err, then wait in break.
            send(1'b0, 8'h3C, CPB, CPB, 1'b0, 40);
            chk("break_busy_held", int'(busy_a), 1);
            rx_a = 1'b1;
            repeat (5) @(negedge clk);
            chk("break_released", int'(busy_a), 0);
            repeat (40) @(negedge clk);
            chk("break_no_restart", int'(busy_a), 0);
            drain(1'b0, 3 * CPB);

            // Reset in the middle of bit 4 of 0x5A.
            rb = 8'h5A;
            rx_a = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 5; i++) begin
               rx_a = rb[i];
               repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clk);
            end
            rst_a = 1'b0; rx_a = 1'b1;
            repeat (3) @(negedge clk);
            rst_a = 1'b1;
            @(negedge clk);
            chk("midrst_data", int'(data_a), 0);
            chk("midrst_busy", int'(busy_a), 0);
            repeat (10) @(negedge clk);
            send(1'b0, 8'hC3, CPB, CPB, 1'b1, CPB);
            drain(1'b0, 3 * CPB);

            // Sender baud off by one clock per bit each way.
            repeat (8) @(negedge clk);
            send(1'b0, 8'h96, 15, CPB, 1'b1, 15);
            repeat (CPB) @(negedge clk);
            drain(1'b0, 3 * CPB);
            send(1'b0, 8'h96, 17, CPB, 1'b1, 17);
            drain(1'b0, 3 * CPB);
            repeat (CPB) @(negedge clk);

            // Random frames, occasional bad stop bit, random gaps.
            for (int n = 0; n < 12; n++) begin
               rb = 8'($urandom);
               if ($urandom_range(0, 5) == 0) begin
                  send(1'b0, rb, CPB, CPB, 1'b0, int'(CPB) + int'($urandom_range(0, 20)));
                  rx_a = 1'b1;
                  repeat (2 + $urandom_range(0, 8)) @(negedge clk);
               end else begin
                  send(1'b0, rb, CPB, CPB, 1'b1, CPB);
                  repeat (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 24)) @(negedge clk);
               end
            end
            drain(1'b0, 3 * CPB);
         end
      join

      repeat (CPB) @(negedge clk);
      chk("a_leftover", q_a.size(), 0);
      chk("b_leftover", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
